// File: rtl/mux_rr_scheduler.sv
// Round-robin owner of the shared 8:1 bit-select mux: grants one requester at a
// time, drives the select, and streams I[S] out as a bounded burst of beats.
module mux_rr_scheduler #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  input  logic [7:0] I,
  output logic [2:0] S,
  output logic [7:0] gnt,
  output logic       F,
  output logic       f_valid,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_e           state_q;
  logic [2:0]       ptr_q;
  logic [CNT_W-1:0] beat_q;
  logic [2:0]       s_q;
  logic [7:0]       gnt_q;
  logic             f_q;
  logic             f_valid_q;
  logic             busy_q;

  logic [2:0]       winner_d;
  logic             found_d;

  // First requester at or after ptr, scanning upward with 3-bit wrap.
  always_comb begin
    winner_d = ptr_q;
    found_d  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!found_d && req[ptr_q + 3'(k)]) begin
        winner_d = ptr_q + 3'(k);
        found_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      beat_q    <= '0;
      s_q       <= 3'd0;
      gnt_q     <= 8'd0;
      f_q       <= 1'b0;
      f_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          f_valid_q <= 1'b0;
          if (en && found_d) begin
            s_q     <= winner_d;
            gnt_q   <= 8'd1 << winner_d;
            busy_q  <= 1'b1;
            beat_q  <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (req[s_q]) begin
            f_q       <= I[s_q];
            f_valid_q <= 1'b1;
            beat_q    <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT) begin
              gnt_q   <= 8'd0;
              busy_q  <= 1'b0;
              ptr_q   <= s_q + 3'd1;
              state_q <= IDLE;
            end
          end else begin
            // Owner dropped its request: release without taking a beat.
            f_valid_q <= 1'b0;
            gnt_q     <= 8'd0;
            busy_q    <= 1'b0;
            ptr_q     <= s_q + 3'd1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign S       = s_q;
  assign gnt     = gnt_q;
  assign F       = f_q;
  assign f_valid = f_valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed and randomized checks of mux_rr_scheduler against a rotation-order
// reference model evaluated once per clock.
module tb_mux_rr_scheduler;
  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] I;
  logic [2:0] S;
  logic [7:0] gnt;
  logic       F;
  logic       f_valid;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: owner index (-1 when idle), beats taken, rotation start.
  int m_owner;
  int m_beats;
  int m_ptr;
  int m_S;
  bit m_F;
  bit m_fv;

  mux_rr_scheduler #(.BURST_LEN(BL), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .I(I),
    .S(S), .gnt(gnt), .F(F), .f_valid(f_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int p, input logic [7:0] r);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_beats = 0; m_ptr = 0; m_S = 0; m_F = 0; m_fv = 0;
  endtask

  task automatic model_step();
    if (m_owner < 0) begin
      m_fv = 0;
      if (en === 1'b1 && req != 8'd0) begin
        m_owner = rr_pick(m_ptr, req);
        m_S     = m_owner;
        m_beats = 0;
      end
    end else if (req[m_owner]) begin
      m_F  = I[m_owner];
      m_fv = 1;
      m_beats++;
      if (m_beats == BL) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end
    end else begin
      m_fv    = 0;
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] exp_gnt;
    exp_gnt = (m_owner < 0) ? 8'd0 : 8'(1 << m_owner);
    check({tag, ".S"},       32'(S),       32'(m_S));
    check({tag, ".gnt"},     32'(gnt),     32'(exp_gnt));
    check({tag, ".F"},       32'(F),       32'(m_F));
    check({tag, ".f_valid"}, 32'(f_valid), 32'(m_fv));
    check({tag, ".busy"},    32'(busy),    32'(m_owner >= 0));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    #1;
    check_all(tag);
  endtask

  // Called just after a checked edge; asserts reset between edges.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    tick("in_rst");
    tick("in_rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int         pulses;
    int         hits7;
    int         order[$];
    bit         prev_busy;
    logic [3:0] pat;
    logic [3:0] fseq;
    int         exp_order[9];

    rst_n = 1'b1; en = 1'b0; req = 8'h00; I = 8'h00;
    model_reset();
    #1;
    do_reset();
    repeat (4) tick("post_rst_idle");

    // Single requester, burst then re-grant after one idle cycle
    en = 1'b1; req = 8'h04; I = 8'h04;
    pulses = 0;
    repeat (5) begin tick("single"); pulses += int'(f_valid); end
    check("single.pulses", 32'(pulses), 32'd4);
    repeat (3) tick("single_regrant");
    do_reset();
    req = 8'h00;
    repeat (4) tick("rst_no_req");

    // Full rotation with every requester active
    req = 8'hFF; prev_busy = 1'b0;
    repeat (41) begin
      tick("rotate");
      if (busy && !prev_busy) order.push_back(int'(S));
      prev_busy = busy;
    end
    exp_order = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    check("rotate.count", 32'(order.size()), 32'd9);
    for (int i = 0; i < 9 && i < order.size(); i++)
      check($sformatf("rotate.order%0d", i), 32'(order[i]), 32'(exp_order[i]));

    // Early release of requester 5 after two beats
    req = 8'h00;
    do_reset();
    req = 8'h20; pulses = 0;
    repeat (3) begin tick("early"); pulses += int'(f_valid); end
    req = 8'h11;
    tick("early_drop"); pulses += int'(f_valid);
    check("early.pulses", 32'(pulses), 32'd2);
    tick("early_next");
    check("early.next_gnt", 32'(gnt), 32'h01);
    repeat (5) tick("early_tail");

    // Enable gating
    req = 8'h00;
    do_reset();
    en = 1'b0; req = 8'h81;
    repeat (3) tick("en_off");
    en = 1'b1;
    tick("en_on");
    check("en.first_gnt", 32'(gnt), 32'h01);
    tick("en_beat");
    en = 1'b0; pulses = 0; hits7 = 0;
    repeat (8) begin tick("en_drop"); pulses += int'(f_valid); hits7 += int'(gnt[7]); end
    check("en.finish_beats", 32'(pulses), 32'd3);
    check("en.no_gnt7", 32'(hits7), 32'd0);

    // Data path through requester 3
    en = 1'b1; req = 8'h00;
    do_reset();
    req = 8'h08; I = 8'($urandom);
    tick("data_gnt");
    pat = 4'b1011; fseq = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      I = 8'($urandom);
      I[3] = pat[3 - b];
      tick("data_beat");
      fseq = {fseq[2:0], F & f_valid};
    end
    check("data.fseq", 32'(fseq), 32'(pat));
    req = 8'h00;
    repeat (2) tick("data_tail");

    // Randomized traffic with occasional mid-cycle resets
    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) req = 8'($urandom & $urandom);
      else if ($urandom_range(0, 5) == 0) req[$urandom_range(0, 7)] = 1'($urandom);
      I = 8'($urandom);
      if ($urandom_range(0, 59) == 0) do_reset();
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
